// File: rtl/vender_pkg.sv
// Shared definitions for the vending datapath: debounce channel states, coin values
// and the downstream vender FSM state codes.
package vender_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    QUAL_HI = 2'd1,
    HELD    = 2'd2,
    QUAL_LO = 2'd3
  } chan_state_t;

  localparam int NICKEL_VAL = 5;
  localparam int DIME_VAL   = 10;

  // Credit states of the vender Moore FSM (cents accumulated).
  typedef enum logic [1:0] {
    V_0C  = 2'd0,
    V_5C  = 2'd1,
    V_10C = 2'd2,
    V_15C = 2'd3
  } vender_state_t;

endpackage

// File: rtl/coin_debounce.sv
// One coin-sensor channel: 2-flop synchronizer, debounce FSM and qualify counter.
// Hold-time jam counter is built only when COIN_JAM_DETECT_EN is defined.
module coin_debounce
  import vender_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int JAM_CYCLES      = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic event_o,
  output logic active_o,
  output logic jam_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 255) begin : g_bad_debounce
    $error("coin_debounce: DEBOUNCE_CYCLES must be 2..255");
  end
  if (JAM_CYCLES < 1) begin : g_bad_jam
    $error("coin_debounce: JAM_CYCLES must be positive");
  end

  logic          sync1_q, s_q;
  chan_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      s_q     <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      s_q     <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (s_q) begin
          state_d = QUAL_HI;
          cnt_d   = CW'(1);
        end
      end
      QUAL_HI: begin
        if (!s_q)                  state_d = IDLE;
        else if (cnt_q == CNT_LAST) state_d = HELD;
        else                       cnt_d   = cnt_q + 1'b1;
      end
      HELD: begin
        if (!s_q) begin
          state_d = QUAL_LO;
          cnt_d   = CW'(1);
        end
      end
      QUAL_LO: begin
        if (s_q)                   state_d = HELD;
        else if (cnt_q == CNT_LAST) state_d = IDLE;
        else                       cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    event_o  = (state_q == QUAL_HI) && s_q && (cnt_q == CNT_LAST);
    active_o = (state_d != IDLE);
  end

`ifdef COIN_JAM_DETECT_EN
  localparam int HW = $clog2(JAM_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(JAM_CYCLES);

  logic [HW-1:0] hold_q, hold_d;
  logic          jam_q, jam_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q <= '0;
      jam_q  <= 1'b0;
    end else begin
      hold_q <= hold_d;
      jam_q  <= jam_d;
    end
  end

  // Hold count saturates at the threshold; jam is sticky until reset.
  always_comb begin
    hold_d = '0;
    if (state_q == HELD) hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;
    jam_d = jam_q | (hold_d == HOLD_MAX);
  end

  assign jam_o = jam_q;
`else
  assign jam_o = 1'b0;
`endif

endmodule

// File: rtl/coin_pulse_conditioner.sv
// Coin front end: debounces nickel/dime sensors and emits exclusive one-cycle J/Y pulses.
// Optional jam detection is enabled by defining COIN_JAM_DETECT_EN.
module coin_pulse_conditioner
  import vender_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int JAM_CYCLES      = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_nickel,
  input  logic raw_dime,
  input  logic accept_en,
  output logic J,
  output logic Y,
  output logic busy,
  output logic jam
);

  logic ev_nk, ev_dm, act_nk, act_dm, jam_nk, jam_dm;

  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .JAM_CYCLES(JAM_CYCLES)) u_nickel (
    .clk(clk), .reset(reset), .raw_i(raw_nickel),
    .event_o(ev_nk), .active_o(act_nk), .jam_o(jam_nk)
  );

  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .JAM_CYCLES(JAM_CYCLES)) u_dime (
    .clk(clk), .reset(reset), .raw_i(raw_dime),
    .event_o(ev_dm), .active_o(act_dm), .jam_o(jam_dm)
  );

  assign jam = jam_nk | jam_dm;

  logic accept, avail_nk, avail_dm;
  logic pend_dm_q, pend_dm_d;
  logic j_q, j_d, y_q, y_d, busy_q, busy_d;

  // Events are arbitrated in the cycle they fire so a pulse lands on the qualifying edge.
  // Nickel always wins, so only a dime that lost needs to wait in pend_dm_q.
  always_comb begin
    accept    = accept_en & ~jam;
    avail_nk  = accept & ev_nk;
    avail_dm  = accept & (pend_dm_q | ev_dm);
    j_d       = avail_nk;
    y_d       = avail_dm & ~avail_nk;
    pend_dm_d = avail_dm & avail_nk;
    busy_d    = act_nk | act_dm | pend_dm_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_dm_q <= 1'b0;
      j_q       <= 1'b0;
      y_q       <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      pend_dm_q <= pend_dm_d;
      j_q       <= j_d;
      y_q       <= y_d;
      busy_q    <= busy_d;
    end
  end

  assign J    = j_q;
  assign Y    = y_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_coin_pulse_conditioner.sv
// Directed bench for coin_pulse_conditioner (DEBOUNCE_CYCLES=4, JAM_CYCLES=50).
// Edge numbers count posedges after the inputs change; outputs are read 1 time unit after the edge.
module tb_coin_pulse_conditioner;

`ifdef COIN_JAM_DETECT_EN
  localparam bit JAM_EN = 1'b1;
`else
  localparam bit JAM_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, raw_nickel, raw_dime, accept_en;
  logic J, Y, busy, jam;

  int checks = 0;
  int errors = 0;
  int jcnt, ycnt, jedge, yedge, both;

  always #5 clk = ~clk;

  coin_pulse_conditioner #(.DEBOUNCE_CYCLES(4), .JAM_CYCLES(50)) dut (
    .clk(clk), .reset(reset), .raw_nickel(raw_nickel), .raw_dime(raw_dime),
    .accept_en(accept_en), .J(J), .Y(Y), .busy(busy), .jam(jam)
  );

  task automatic clear_obs();
    jcnt = 0; ycnt = 0; jedge = -1; yedge = -1; both = 0;
  endtask

  task automatic tick(input int e);
    @(posedge clk);
    #1;
    if (J === 1'b1) begin jcnt++; if (jedge < 0) jedge = e; end
    if (Y === 1'b1) begin ycnt++; if (yedge < 0) yedge = e; end
    if (J === 1'b1 && Y === 1'b1) both++;
  endtask

  task automatic do_reset();
    reset = 1'b1; raw_nickel = 1'b0; raw_dime = 1'b0; accept_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    clear_obs();
  endtask

  task automatic test_reset();
    raw_nickel = 1'b1; raw_dime = 1'b1; accept_en = 1'b1; reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (J !== 1'b0)    begin errors++; $display("FAIL reset_J: got %b expected 0", J); end
    checks++; if (Y !== 1'b0)    begin errors++; $display("FAIL reset_Y: got %b expected 0", Y); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (jam !== 1'b0)  begin errors++; $display("FAIL reset_jam: got %b expected 0", jam); end
  endtask

  task automatic test_clean_nickel();
    do_reset();
    raw_nickel = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      tick(e);
      if (e == 20) raw_nickel = 1'b0;
      if (e == 2)  begin checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clean_busy_e2: got %b expected 0", busy); end end
      if (e == 3)  begin checks++; if (busy !== 1'b1) begin errors++; $display("FAIL clean_busy_e3: got %b expected 1", busy); end end
      if (e == 25) begin checks++; if (busy !== 1'b1) begin errors++; $display("FAIL clean_busy_e25: got %b expected 1", busy); end end
      if (e == 26) begin checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clean_busy_e26: got %b expected 0", busy); end end
    end
    checks++; if (jcnt != 1)  begin errors++; $display("FAIL clean_jcnt: got %0d expected 1", jcnt); end
    checks++; if (jedge != 6) begin errors++; $display("FAIL clean_jedge: got %0d expected 6", jedge); end
    checks++; if (ycnt != 0)  begin errors++; $display("FAIL clean_ycnt: got %0d expected 0", ycnt); end
  endtask

  task automatic test_bounce();
    do_reset();
    raw_dime = 1'b1;
    for (int e = 1; e <= 45; e++) begin
      tick(e);
      if (e == 3 || e == 9 || e == 22) raw_dime = 1'b0;
      if (e == 6 || e == 12)           raw_dime = 1'b1;
    end
    checks++; if (ycnt != 1)   begin errors++; $display("FAIL bounce_ycnt: got %0d expected 1", ycnt); end
    checks++; if (yedge != 18) begin errors++; $display("FAIL bounce_yedge: got %0d expected 18", yedge); end
    checks++; if (jcnt != 0)   begin errors++; $display("FAIL bounce_jcnt: got %0d expected 0", jcnt); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    raw_nickel = 1'b1; raw_dime = 1'b1;
    for (int e = 1; e <= 30; e++) begin
      tick(e);
      if (e == 10) begin raw_nickel = 1'b0; raw_dime = 1'b0; end
    end
    checks++; if (jedge != 6) begin errors++; $display("FAIL simul_jedge: got %0d expected 6", jedge); end
    checks++; if (yedge != 7) begin errors++; $display("FAIL simul_yedge: got %0d expected 7", yedge); end
    checks++; if (jcnt != 1 || ycnt != 1) begin errors++; $display("FAIL simul_counts: got J=%0d Y=%0d expected 1 1", jcnt, ycnt); end
    checks++; if (both != 0)  begin errors++; $display("FAIL simul_overlap: got %0d expected 0", both); end
  endtask

  task automatic test_inhibit();
    do_reset();
    accept_en = 1'b0; raw_nickel = 1'b1;
    for (int e = 1; e <= 55; e++) begin
      tick(e);
      if (e == 10) accept_en = 1'b1;
      if (e == 15) raw_nickel = 1'b0;
      if (e == 35) raw_nickel = 1'b1;
      if (e == 35) begin checks++; if (jcnt != 0) begin errors++; $display("FAIL inhibit_jcnt: got %0d expected 0", jcnt); end end
      if (e == 50) raw_nickel = 1'b0;
    end
    checks++; if (jcnt != 1)   begin errors++; $display("FAIL inhibit_recover_jcnt: got %0d expected 1", jcnt); end
    checks++; if (jedge != 41) begin errors++; $display("FAIL inhibit_recover_jedge: got %0d expected 41", jedge); end
  endtask

  task automatic test_reset_midqual();
    do_reset();
    raw_nickel = 1'b1;
    for (int e = 1; e <= 25; e++) begin
      tick(e);
      if (e == 4) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midq_busy_pre: got %b expected 1", busy); end
        reset = 1'b1;
      end
      if (e == 5) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midq_busy_rst: got %b expected 0", busy); end
        reset = 1'b0;
      end
    end
    raw_nickel = 1'b0;
    checks++; if (jcnt != 1)   begin errors++; $display("FAIL midq_jcnt: got %0d expected 1", jcnt); end
    checks++; if (jedge != 11) begin errors++; $display("FAIL midq_jedge: got %0d expected 11", jedge); end
  endtask

  task automatic test_long_hold();
    do_reset();
    raw_nickel = 1'b1;
    for (int e = 1; e <= 100; e++) begin
      tick(e);
      if (e == 55) begin checks++; if (jam !== 1'b0) begin errors++; $display("FAIL hold_jam_e55: got %b expected 0", jam); end end
      if (e == 56) begin checks++; if (jam !== JAM_EN) begin errors++; $display("FAIL hold_jam_e56: got %b expected %b", jam, JAM_EN); end end
      if (e == 60) raw_nickel = 1'b0;
      if (e == 69) raw_dime = 1'b1;
      if (e == 80) raw_dime = 1'b0;
    end
    checks++; if (jcnt != 1) begin errors++; $display("FAIL hold_jcnt: got %0d expected 1", jcnt); end
    checks++; if (ycnt != (JAM_EN ? 0 : 1)) begin errors++; $display("FAIL hold_ycnt: got %0d expected %0d", ycnt, JAM_EN ? 0 : 1); end
    checks++; if (jam !== JAM_EN) begin errors++; $display("FAIL hold_jam_sticky: got %b expected %b", jam, JAM_EN); end
    do_reset();
    checks++; if (jam !== 1'b0) begin errors++; $display("FAIL hold_jam_cleared: got %b expected 0", jam); end
  endtask

  initial begin
    reset = 1'b1; raw_nickel = 1'b0; raw_dime = 1'b0; accept_en = 1'b1;
    clear_obs();
    test_reset();
    test_clean_nickel();
    test_bounce();
    test_simultaneous();
    test_inhibit();
    test_reset_midqual();
    test_long_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
